// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with byte FIFO and sticky overflow.
// Baud timing is derived from the core clock by a CLK_DIV divider.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 217,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [DEPTH_LOG2-1:0] rd_q, wr_q;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_q, tx_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  push, pop, tick;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;

  assign push = wr_en & ~full;
  assign tick = (baud_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (!empty) pop = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a pop always launches a fresh frame, also straight out of STOP
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      shift_d = mem_q[rd_q];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + NW'(1);
    else if (pop && !push) cnt_d = cnt_q - NW'(1);
    ovf_d = ovf_q;
    if (wr_en && full) ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
      if (push) wr_q <= wr_q + DEPTH_LOG2'(1);
      if (pop)  rd_q <= rd_q + DEPTH_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic
// against a timeline model of frames and FIFO occupancy.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int DIV2  = 217;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic full, empty, overflow, busy, tx;
  logic [DL:0] count;

  logic wr2 = 1'b0;
  logic [7:0] d2 = '0;
  logic full2, empty2, ovf2, busy2, tx2;
  logic [4:0] count2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(DIV), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .busy(busy), .tx(tx)
  );

  uart_tx_fifo #(.CLK_DIV(DIV2), .DEPTH_LOG2(4)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .wr_data(d2),
    .ovf_clr(1'b0), .full(full2), .empty(empty2), .count(count2),
    .overflow(ovf2), .busy(busy2), .tx(tx2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // model: pending bytes, the frame currently on the line, sticky flag
  logic [7:0] mq[$];
  bit act = 0, started = 0, m_ovf = 0;
  int cur_start = 0;
  logic [7:0] cur_byte = '0;
  int c2 = -100000;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at edge %0d",
                 tag, got, exp, edge_n);
    end
  endtask

  function automatic logic frame_bit(input int t0, input int div,
                                     input logic [7:0] b, input int e);
    int k;
    if (e < t0 + 1 || e > t0 + 10 * div) return 1'b1;
    k = (e - t0 - 1) / div;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic step(input bit w, input logic [7:0] d, input bit c);
    bit fullm;
    logic et;
    wr_en = w; wr_data = d; ovf_clr = c;
    @(posedge clk);
    edge_n++;
    fullm = (mq.size() == DEPTH);
    if (act && edge_n == cur_start + 10 * DIV) act = 0;
    if (!act && mq.size() > 0) begin
      cur_byte = mq.pop_front();
      cur_start = edge_n;
      act = 1; started = 1;
    end
    if (w && !fullm) mq.push_back(d);
    if (w && fullm) m_ovf = 1;
    else if (c)     m_ovf = 0;
    #1;
    et = started ? frame_bit(cur_start, DIV, cur_byte, edge_n) : 1'b1;
    check("tx", tx, et);
    check("busy", busy, act);
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("tx2", tx2, frame_bit(c2 + 1, DIV2, 8'h55, edge_n));
    check("busy2", busy2, edge_n >= c2 + 1 && edge_n <= c2 + 10 * DIV2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_ovf", overflow, 1'b0);
    mq.delete();
    act = 0; started = 0; m_ovf = 0;
    c2 = -100000;
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    mid_reset();
    idle(50);

    step(1, 8'hA5, 0);
    idle(45);

    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0);
    idle(130);

    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0);
    check("burst_ovf", overflow, 1'b1);
    step(0, 8'h00, 1);
    check("ovf_cleared", overflow, 1'b0);
    idle(230);

    // tx is low during data bit 2 of an all-zero frame
    step(1, 8'h00, 0);
    idle(15);
    check("pre_rst_tx", tx, 1'b0);
    mid_reset();
    step(1, 8'h3C, 0);
    idle(45);

    for (int seg = 0; seg < 6; seg++) begin
      int p;
      p = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 99) < p, 8'($urandom),
             $urandom_range(0, 19) == 0);
    end
    idle(220);

    wr2 = 1'b1; d2 = 8'h55;
    c2 = edge_n + 1;
    step(0, 8'h00, 0);
    wr2 = 1'b0;
    idle(10 * DIV2 + 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
